// File: rtl/mem_ctrl.sv
// Memory-bus access controller: REQ handshake to an EN/MFC asynchronous memory interface.
// Optional MEM_TIMEOUT_EN build adds an MFC-edge timeout with DONE/ERR abort pulse.
module mem_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        REQ,
   input  logic        REQ_RW,
   input  logic [15:0] REQ_ADDR,
   input  logic [15:0] REQ_WDATA,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] RDATA,
   output logic        ERR,
   output logic [15:0] MAR_to_MEM,
   output logic [15:0] MDR_to_MEM,
   output logic        RW,
   output logic        EN,
   input  logic        MFC,
   input  logic [15:0] MEM_to_MDR
);

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 16;

   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("mem_ctrl: TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      STROBE   = 3'd2,
      WAIT_MFC = 3'd3,
      RELEASE  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic            mfc_meta, mfc_s;
   logic [AW-1:0]   mar_d;
   logic [DW-1:0]   mdr_d, rdata_d;
   logic            rw_d, en_d, busy_d, done_d;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_d;
`endif

   // Two-flop synchronizer for the asynchronous completion strobe
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         mfc_meta <= 1'b0;
         mfc_s    <= 1'b0;
      end else begin
         mfc_meta <= MFC;
         mfc_s    <= mfc_meta;
      end
   end

   // State and registered outputs
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         MAR_to_MEM <= '0;
         MDR_to_MEM <= '0;
         RW         <= 1'b0;
         EN         <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         RDATA      <= '0;
      end else begin
         state_q    <= state_d;
         MAR_to_MEM <= mar_d;
         MDR_to_MEM <= mdr_d;
         RW         <= rw_d;
         EN         <= en_d;
         BUSY       <= busy_d;
         DONE       <= done_d;
         RDATA      <= rdata_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         cnt_q <= '0;
         ERR   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ERR   <= err_d;
      end
   end
`else
   assign ERR = 1'b0;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      mar_d   = MAR_to_MEM;
      mdr_d   = MDR_to_MEM;
      rw_d    = RW;
      en_d    = EN;
      done_d  = 1'b0;
      rdata_d = RDATA;
`ifdef MEM_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            en_d = 1'b0;
            if (REQ) begin
               mar_d   = REQ_ADDR;
               mdr_d   = REQ_WDATA;
               rw_d    = REQ_RW;
               state_d = SETUP;
            end
         end
         SETUP: begin
            en_d    = 1'b1;
            state_d = STROBE;
         end
         STROBE: begin
            en_d    = 1'b1;
            state_d = WAIT_MFC;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT_MFC: begin
            if (mfc_s) begin
               en_d    = 1'b0;
               state_d = RELEASE;
               if (RW) rdata_d = MEM_to_MDR;
`ifdef MEM_TIMEOUT_EN
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               en_d    = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
`endif
            end
         end
         RELEASE: begin
            en_d = 1'b0;
            if (!mfc_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
`ifdef MEM_TIMEOUT_EN
            end else if (cnt_q == TIMEOUT_LAST) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
`endif
            end
         end
         default: begin
            en_d    = 1'b0;
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule
